router_sync: RTL



---
 rtl/router_sync.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/router_sync.sv
// ---------------------------------------------------------------------------
// router_sync
// Glue between the router FSM, the three output FIFOs and the downstream
// readers. Latches the destination port from the header, steers the FSM
// write strobe to the addressed FIFO, reflects FIFO flags back to the FSM
// and the readers, and soft-resets any port whose data sits unread for
// TIMEOUT consecutive cycles.
//
// Parameters
//   TIMEOUT        consecutive unread-valid cycles before a soft reset (2..255)
//
// Ports
//   clk            clock, all state updates on the rising edge
//   reset          asynchronous active-high reset
//   detect_add     FSM address-decode strobe; latch data_in into addr
//   data_in        header address field (00/01/10 = port 0/1/2, 11 = invalid)
//   write_enb_reg  FSM request to write the current byte
//   read_enb_n     downstream read strobe for port n
//   empty_n        FIFO n empty flag
//   full_n         FIFO n full flag
//   write_enb      one-hot FIFO write enable (combinational)
//   fifo_full      full flag of the addressed FIFO (combinational)
//   vld_out_n      port n has data available (combinational)
//   soft_reset_n   registered one-cycle timeout pulse for port n
// ---------------------------------------------------------------------------
module router_sync #(
    parameter int unsigned TIMEOUT = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       detect_add,
    input  logic [1:0] data_in,
    input  logic       write_enb_reg,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    localparam int unsigned NUM_PORTS = 3;
    localparam int unsigned CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ADDR_P0  = 2'b00;
    localparam logic [1:0] ADDR_P1  = 2'b01;
    localparam logic [1:0] ADDR_P2  = 2'b10;

    logic [1:0]           addr;
    logic [NUM_PORTS-1:0] vld;
    logic [NUM_PORTS-1:0] rd;
    logic [NUM_PORTS-1:0] soft_rst;

    // Destination address latch; the invalid code 11 is kept as-is so that
    // the steering logic below suppresses writes for it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr <= 2'b00;
        end else if (detect_add) begin
            addr <= data_in;
        end
    end

    // Write steering: uses the registered addr, so a header decoded in the
    // same cycle only takes effect on the following cycle.
    always_comb begin
        write_enb = 3'b000;
        if (write_enb_reg) begin
            case (addr)
                ADDR_P0: write_enb = 3'b001;
                ADDR_P1: write_enb = 3'b010;
                ADDR_P2: write_enb = 3'b100;
                default: write_enb = 3'b000;
            endcase
        end
    end

    // Full flag of the addressed FIFO; an invalid address never reports full.
    always_comb begin
        fifo_full = 1'b0;
        case (addr)
            ADDR_P0: fifo_full = full_0;
            ADDR_P1: fifo_full = full_1;
            ADDR_P2: fifo_full = full_2;
            default: fifo_full = 1'b0;
        endcase
    end

    // Valid is simply "FIFO not empty", with no added latency.
    assign vld = {~empty_2, ~empty_1, ~empty_0};
    assign rd  = {read_enb_2, read_enb_1, read_enb_0};

    assign vld_out_0 = vld[0];
    assign vld_out_1 = vld[1];
    assign vld_out_2 = vld[2];

    // Per-port stall watchdog: counts edges where data is valid but unread.
    // Any read or empty edge restarts the count; reaching TIMEOUT-1 on a
    // stalled edge emits a one-cycle pulse and restarts from zero, so a
    // persistent stall pulses once every TIMEOUT cycles.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [CNT_W-1:0] cnt_q;
        logic             sr_q;
        logic             stall;

        assign stall = vld[p] & ~rd[p];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
                sr_q  <= 1'b0;
            end else if (stall) begin
                if (cnt_q == CNT_MAX) begin
                    cnt_q <= '0;
                    sr_q  <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    sr_q  <= 1'b0;
                end
            end else begin
                cnt_q <= '0;
                sr_q  <= 1'b0;
            end
        end

        assign soft_rst[p] = sr_q;
    end

    assign soft_reset_0 = soft_rst[0];
    assign soft_reset_1 = soft_rst[1];
    assign soft_reset_2 = soft_rst[2];

endmodule
